// File: rtl/riscv_dbg_pkg.sv
// Shared definitions for the run-control / register-dump monitor:
// FSM encoding, halt-cause codes and the default halt instruction.
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_STALL   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0010_0073;

  // Fixed arbitration when several stop conditions fire on the same cycle.
  function automatic logic [1:0] stop_cause(input logic ebreak, input logic stall,
                                            input logic timeout);
    if (ebreak)       return CAUSE_EBREAK;
    else if (stall)   return CAUSE_STALL;
    else if (timeout) return CAUSE_TIMEOUT;
    else              return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/riscv_run_monitor_if.sv
// Register-dump stream: one snapshot register per beat, valid/ready handshake.
interface riscv_run_monitor_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int IW = $clog2(NREGS);

  logic            dump_valid;
  logic            dump_ready;
  logic [IW-1:0]   dump_index;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;

  modport master (output dump_valid, dump_index, dump_data, dump_last, input dump_ready);
  modport slave  (input dump_valid, dump_index, dump_data, dump_last, output dump_ready);
endinterface

// File: rtl/dump_serializer.sv
// Holds the frozen register snapshot and walks it out one register per
// accepted beat; index/data stay put while the sink back-pressures.
module dump_serializer #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [NREGS*XLEN-1:0] i_regs,
  output logic                  o_fire_last,
  riscv_run_monitor_if.master   dump
);
  localparam int IW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] r_snap;
  logic [IW-1:0]              r_idx;
  logic                       r_valid;
  logic                       w_fire;
  logic                       w_last;

  assign w_fire      = r_valid & dump.dump_ready;
  assign w_last      = (r_idx == IW'(NREGS - 1));
  assign o_fire_last = w_fire & w_last;

  // Snapshot content is don't-care out of reset, so no reset on this bank.
  always_ff @(posedge clk) begin
    if (i_load) r_snap <= i_regs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_idx   <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  // Data is gated so the port reads zero whenever no beat is offered.
  assign dump.dump_valid = r_valid;
  assign dump.dump_index = r_idx;
  assign dump.dump_data  = r_valid ? r_snap[r_idx] : '0;
  assign dump.dump_last  = r_valid & w_last;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run-control monitor: counts RUN cycles, stops on EBREAK / PC stall / timeout,
// holds the core and hands a register snapshot to the dump serializer.
module riscv_run_monitor
  import riscv_dbg_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NREGS       = 32,
  parameter int          MAX_CYCLES  = 3000,
  parameter int          STALL_LIMIT = 8,
  parameter logic [31:0] HALT_INSN   = HALT_INSN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           Instruction,
  input  logic [XLEN-1:0]       PCOut,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [1:0]            halt_cause,
  output logic [31:0]           cycle_count,
  riscv_run_monitor_if.master   dump
);

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_cycle;
  logic [31:0]     r_stall;
  logic [XLEN-1:0] r_prev_pc;
  logic            r_prev_vld;
  logic [1:0]      r_cause;

  logic        w_ebreak, w_stall_hit, w_timeout, w_stop, w_load, w_fire_last;
  logic [31:0] w_stall_nxt;
  logic [1:0]  w_cause;

  // The stall counter looks one cycle ahead so STALL_LIMIT identical PCs
  // in a row stop the run on the last of them.
  assign w_ebreak    = (Instruction == HALT_INSN);
  assign w_stall_nxt = (r_prev_vld && (PCOut == r_prev_pc)) ? r_stall + 32'd1 : 32'd0;
  assign w_stall_hit = (w_stall_nxt == 32'(STALL_LIMIT - 1));
  assign w_timeout   = (r_cycle == 32'(MAX_CYCLES - 1));
  assign w_stop      = w_ebreak | w_stall_hit | w_timeout;
  assign w_cause     = stop_cause(w_ebreak, w_stall_hit, w_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: if (w_stop) begin
        w_state_nxt = ST_DUMP;
        w_load      = 1'b1;
      end
      ST_DUMP: if (w_fire_last) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle    <= '0;
      r_stall    <= '0;
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
      r_cause    <= CAUSE_NONE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: if (start) begin
          r_cycle    <= '0;
          r_stall    <= '0;
          r_prev_vld <= 1'b0;
          r_cause    <= CAUSE_NONE;
        end
        ST_RUN: if (w_stop) begin
          r_cause <= w_cause;
        end else begin
          r_cycle    <= (r_cycle == '1) ? r_cycle : r_cycle + 32'd1;
          r_stall    <= w_stall_nxt;
          r_prev_pc  <= PCOut;
          r_prev_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_hold    = (r_state == ST_DUMP) || (r_state == ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign halt_cause  = r_cause;
  assign cycle_count = r_cycle;

  dump_serializer #(.XLEN(XLEN), .NREGS(NREGS)) u_ser (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_regs      (regs_flat),
    .o_fire_last (w_fire_last),
    .dump        (dump)
  );

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench for riscv_run_monitor: a 32x32 build and a 16x64 build.
module tb_riscv_run_monitor;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // main build: XLEN=32 NREGS=32 MAX_CYCLES=100 STALL_LIMIT=8
  logic          start = 0, ready = 0;
  logic [31:0]   insn = NOP, pc = 0;
  logic [1023:0] regs = '0;
  logic          hold, done;
  logic [1:0]    cause;
  logic [31:0]   cyc;
  logic [31:0]   gold [32];

  riscv_run_monitor_if #(.XLEN(32), .NREGS(32)) dif ();
  assign dif.dump_ready = ready;

  riscv_run_monitor #(.XLEN(32), .NREGS(32), .MAX_CYCLES(100), .STALL_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .Instruction(insn), .PCOut(pc),
    .regs_flat(regs), .cpu_hold(hold), .done(done), .halt_cause(cause),
    .cycle_count(cyc), .dump(dif)
  );

  // wide build: XLEN=64 NREGS=16 MAX_CYCLES=20 STALL_LIMIT=4
  logic          start2 = 0, ready2 = 0;
  logic [31:0]   insn2 = NOP;
  logic [63:0]   pc2 = 0;
  logic [1023:0] regs2 = '0;
  logic          hold2, done2;
  logic [1:0]    cause2;
  logic [31:0]   cyc2;
  logic [63:0]   gold2 [16];

  riscv_run_monitor_if #(.XLEN(64), .NREGS(16)) dif2 ();
  assign dif2.dump_ready = ready2;

  riscv_run_monitor #(.XLEN(64), .NREGS(16), .MAX_CYCLES(20), .STALL_LIMIT(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .Instruction(insn2), .PCOut(pc2),
    .regs_flat(regs2), .cpu_hold(hold2), .done(done2), .halt_cause(cause2),
    .cycle_count(cyc2), .dump(dif2)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_gold(input logic [31:0] seed);
    for (int i = 0; i < 32; i++) begin
      gold[i] = (seed ^ (32'(i) * 32'h0101_0101)) + 32'(i);
      regs[i*32 +: 32] = gold[i];
    end
  endtask

  // Start from IDLE/DONE and feed n RUN cycles; PC freezes from freeze_at on.
  task automatic run_main(input int n, input int ebreak_at, input int freeze_at);
    start = 1; step; start = 0;
    for (int k = 0; k < n; k++) begin
      pc   = (freeze_at >= 0 && k >= freeze_at) ? 32'h1000 + 32'(4*freeze_at)
                                                : 32'h1000 + 32'(4*k);
      insn = (k == ebreak_at) ? EBREAK : NOP;
      step;
      if (k == n - 2) begin
        checks++;
        if (hold !== 1'b0) begin
          errors++; $display("FAIL early_stop k=%0d: hold=%b want 0", k, hold);
        end
      end
    end
    insn = NOP;
  endtask

  task automatic check_stop(input string tag, input logic [1:0] ecause, input logic [31:0] ecyc);
    checks++;
    if (hold !== 1'b1 || cause !== ecause || cyc !== ecyc || dif.dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s stop: hold=%b cause=%0d cyc=%0d valid=%b, want 1/%0d/%0d/1",
               tag, hold, cause, cyc, dif.dump_valid, ecause, ecyc);
    end
  endtask

  task automatic drain_main(input string tag);
    ready = 1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dif.dump_valid !== 1'b1 || dif.dump_index !== 5'(i) || dif.dump_data !== gold[i] ||
          dif.dump_last !== (i == 31)) begin
        errors++;
        $display("FAIL %s beat%0d: valid=%b idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                 tag, i, dif.dump_valid, dif.dump_index, dif.dump_data, dif.dump_last,
                 i, gold[i], (i == 31));
      end
      step;
    end
    checks++;
    if (dif.dump_valid !== 1'b0 || done !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL %s end: valid=%b done=%b hold=%b, want 0/1/1", tag, dif.dump_valid, done, hold);
    end
  endtask

  task automatic test_reset;
    step; step;
    checks++;
    if (hold !== 0 || done !== 0 || cause !== 0 || cyc !== 0 || dif.dump_valid !== 0 ||
        dif.dump_index !== 0 || dif.dump_data !== 0 || dif.dump_last !== 0 || dif2.dump_valid !== 0) begin
      errors++;
      $display("FAIL reset: hold=%b done=%b cause=%0d cyc=%0d valid=%b idx=%0d data=%h, want all 0",
               hold, done, cause, cyc, dif.dump_valid, dif.dump_index, dif.dump_data);
    end
    reset = 0; step;
  endtask

  task automatic test_ebreak;
    set_gold(32'hA000_0000);
    run_main(41, 40, -1);
    check_stop("ebreak", 2'd1, 32'd40);
    drain_main("ebreak");
  endtask

  task automatic test_stall;
    set_gold(32'h1234_5678);
    run_main(18, -1, 10);
    check_stop("stall", 2'd2, 32'd17);
    regs = ~regs;
    drain_main("stall");
  endtask

  task automatic test_timeout;
    set_gold(32'hDEAD_0000);
    run_main(100, -1, -1);
    check_stop("timeout", 2'd3, 32'd99);
    drain_main("timeout");
  endtask

  task automatic test_ready_toggle;
    int exp;
    logic rdy, pstall;
    logic [4:0] pidx;
    logic [31:0] pdata;
    exp = 0; pstall = 0; pidx = 0; pdata = 0;
    set_gold(32'h5A5A_0F0F);
    ready = 0;
    run_main(6, 5, -1);
    check_stop("toggle", 2'd1, 32'd5);
    for (int c = 0; c < 300 && exp < 32; c++) begin
      checks++;
      if (dif.dump_valid !== 1'b1 || dif.dump_index !== 5'(exp) || dif.dump_data !== gold[exp] ||
          (pstall && (dif.dump_index !== pidx || dif.dump_data !== pdata))) begin
        errors++;
        $display("FAIL toggle c=%0d: valid=%b idx=%0d data=%h, want idx=%0d data=%h",
                 c, dif.dump_valid, dif.dump_index, dif.dump_data, exp, gold[exp]);
      end
      rdy    = (c % 3 != 1) && (c % 7 != 3);
      pstall = !rdy;
      pidx   = dif.dump_index;
      pdata  = dif.dump_data;
      if (rdy) exp++;
      ready = rdy;
      step;
    end
    checks++;
    if (exp != 32 || dif.dump_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL toggle end: beats=%0d valid=%b done=%b, want 32/0/1", exp, dif.dump_valid, done);
    end
  endtask

  task automatic test_reset_mid_dump;
    set_gold(32'h0BAD_F00D);
    run_main(4, 3, -1);
    check_stop("middump", 2'd1, 32'd3);
    ready = 1;
    for (int i = 0; i < 10; i++) step;
    checks++;
    if (dif.dump_valid !== 1'b1 || dif.dump_index !== 5'd10) begin
      errors++; $display("FAIL middump beat10: valid=%b idx=%0d want 1/10", dif.dump_valid, dif.dump_index);
    end
    reset = 1; #1;
    checks++;
    if (dif.dump_valid !== 0 || dif.dump_index !== 0 || dif.dump_data !== 0 || hold !== 0 ||
        done !== 0 || cause !== 0 || cyc !== 0) begin
      errors++;
      $display("FAIL middump reset: valid=%b idx=%0d data=%h hold=%b done=%b cause=%0d cyc=%0d want 0",
               dif.dump_valid, dif.dump_index, dif.dump_data, hold, done, cause, cyc);
    end
    #1 reset = 0; #1;
    set_gold(32'h7777_1111);
    run_main(3, 2, -1);
    check_stop("rerun", 2'd1, 32'd2);
    drain_main("rerun");
  endtask

  task automatic test_priority;
    set_gold(32'hC0DE_0000);
    run_main(100, 99, -1);
    check_stop("prio", 2'd1, 32'd99);
    drain_main("prio");
  endtask

  task automatic test_wide;
    for (int i = 0; i < 16; i++) begin
      gold2[i] = {32'hFEED_0000 + 32'(i), 32'h0000_ABCD ^ 32'(i * 3)};
      regs2[i*64 +: 64] = gold2[i];
    end
    start2 = 1; step; start2 = 0;
    for (int k = 0; k < 20; k++) begin
      pc2   = 64'h8000_0000_0000 + 64'(8*k);
      insn2 = (k == 19) ? EBREAK : NOP;
      step;
    end
    insn2 = NOP;
    checks++;
    if (hold2 !== 1'b1 || cause2 !== 2'd1 || cyc2 !== 32'd19) begin
      errors++; $display("FAIL wide stop: hold=%b cause=%0d cyc=%0d want 1/1/19", hold2, cause2, cyc2);
    end
    ready2 = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dif2.dump_valid !== 1'b1 || dif2.dump_index !== 4'(i) || dif2.dump_data !== gold2[i] ||
          dif2.dump_last !== (i == 15)) begin
        errors++;
        $display("FAIL wide beat%0d: valid=%b idx=%0d data=%h last=%b want data=%h",
                 i, dif2.dump_valid, dif2.dump_index, dif2.dump_data, dif2.dump_last, gold2[i]);
      end
      step;
    end
    checks++;
    if (dif2.dump_valid !== 1'b0 || done2 !== 1'b1) begin
      errors++; $display("FAIL wide end: valid=%b done=%b want 0/1", dif2.dump_valid, done2);
    end
  endtask

  initial begin
    test_reset;
    test_ebreak;
    test_stall;
    test_timeout;
    test_ready_toggle;
    test_reset_mid_dump;
    test_priority;
    test_wide;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
